// File: rtl/sram_bist_pkg.sv
// Shared encodings and the March C- element table for the SRAM BIST controller.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_WR,
    PH_RD_ISS,
    PH_RD_CHK
  } phase_t;

  // Background patterns; the controller replicates a single bit across the data width.
  localparam logic [7:0] BG0 = 8'h00;
  localparam logic [7:0] BG1 = 8'hFF;

  localparam logic [2:0] LAST_ELEM = 3'd5;

  // One March element: walk direction, whether it reads/writes, and which background
  // is expected on the read and stored on the write (0 = BG0, 1 = BG1).
  typedef struct packed {
    logic down;
    logic has_rd;
    logic has_wr;
    logic exp_one;
    logic wr_one;
  } elem_t;

  localparam elem_t E0   = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, exp_one: 1'b0, wr_one: 1'b0};
  localparam elem_t E1   = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, exp_one: 1'b0, wr_one: 1'b1};
  localparam elem_t E2   = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, exp_one: 1'b1, wr_one: 1'b0};
  localparam elem_t E3   = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, exp_one: 1'b0, wr_one: 1'b1};
  localparam elem_t E4   = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, exp_one: 1'b1, wr_one: 1'b0};
  localparam elem_t E5   = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, exp_one: 1'b0, wr_one: 1'b0};
  localparam elem_t ENUL = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b0, exp_one: 1'b0, wr_one: 1'b0};

  // Padded to 8 entries so any 3-bit element index (including "one past the last") is in range.
  localparam elem_t [7:0] ELEM_TABLE = {ENUL, ENUL, E5, E4, E3, E2, E1, E0};

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for the March walk, with load-first and last-address detection.
module march_addr_gen #(
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 262144
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_load_down,
  input  logic              i_step,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr;

  // Load the first address of a new element, otherwise step in the element's direction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_down ? TOP_ADDR : '0;
    end else if (i_step) begin
      r_addr <= i_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_down ? (r_addr == '0) : (r_addr == TOP_ADDR);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller in front of the SRAM; passes functional traffic through when not testing.
import sram_bist_pkg::*;

module sram_march_bist #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 262144
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              func_CEN,
  input  logic              func_WEN,
  input  logic [ADDR_W-1:0] func_A,
  input  logic [DATA_W-1:0] func_D,
  input  logic [DATA_W-1:0] Q_in,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_expect
);

  state_t            r_state;
  phase_t            r_phase;
  logic [2:0]        r_elem;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;
  logic [DATA_W-1:0] r_fail_expect;

  elem_t             w_elem;
  logic [2:0]        w_next_idx;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch;
  logic              w_start_acc;
  logic              w_advance;
  logic              w_elem_end;
  logic              w_step;
  logic              w_load;
  logic              w_load_down;

  assign w_elem      = ELEM_TABLE[r_elem];
  assign w_next_idx  = r_elem + 3'd1;
  assign w_exp       = {DATA_W{w_elem.exp_one}};
  assign w_mismatch  = (r_state == ST_RUN) && (r_phase == PH_RD_CHK) && (Q_in != w_exp);
  assign w_start_acc = start && (r_state != ST_RUN);

  // An address is finished after its write, or after the check when the element has no write.
  assign w_advance   = (r_state == ST_RUN) &&
                       ((r_phase == PH_WR) ||
                        ((r_phase == PH_RD_CHK) && !w_mismatch && !w_elem.has_wr));
  assign w_elem_end  = w_advance && w_last;
  assign w_step      = w_advance && !w_last;
  assign w_load      = w_start_acc || (w_elem_end && (r_elem != LAST_ELEM));
  assign w_load_down = w_start_acc ? ELEM_TABLE[3'd0].down : ELEM_TABLE[w_next_idx].down;

  march_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .i_down      (w_elem.down),
    .o_addr      (w_addr),
    .o_last      (w_last)
  );

  // Main sequencer: walks elements and phases, records the first mismatch, and manages status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_phase       <= PH_WR;
      r_elem        <= 3'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_addr   <= '0;
      r_fail_data   <= '0;
      r_fail_expect <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state       <= ST_RUN;
            r_phase       <= PH_WR;
            r_elem        <= 3'd0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
            r_fail_expect <= '0;
          end
        end
        ST_RUN: begin
          if (w_mismatch) begin
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_fail        <= 1'b1;
            r_fail_addr   <= w_addr;
            r_fail_data   <= Q_in;
            r_fail_expect <= w_exp;
          end else if (r_phase == PH_RD_ISS) begin
            r_phase <= PH_RD_CHK;
          end else if ((r_phase == PH_RD_CHK) && w_elem.has_wr) begin
            r_phase <= PH_WR;
          end else if (w_elem_end) begin
            if (r_elem == LAST_ELEM) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_elem  <= w_next_idx;
              r_phase <= ELEM_TABLE[w_next_idx].has_rd ? PH_RD_ISS : PH_WR;
            end
          end else begin
            r_phase <= w_elem.has_rd ? PH_RD_ISS : PH_WR;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // While testing the BIST owns the SRAM; otherwise the functional port goes straight through.
  assign CEN = r_busy ? 1'b0                      : func_CEN;
  assign WEN = r_busy ? (r_phase != PH_WR)        : func_WEN;
  assign A   = r_busy ? w_addr                    : func_A;
  assign D   = r_busy ? {DATA_W{w_elem.wr_one}}   : func_D;

  assign busy        = r_busy;
  assign done        = r_done;
  assign fail        = r_fail;
  assign fail_addr   = r_fail_addr;
  assign fail_data   = r_fail_data;
  assign fail_expect = r_fail_expect;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist: two instances (16 and 32 addresses) with SRAM models.
module tb_sram_march_bist;

  localparam int AW      = 18;
  localparam int DW      = 8;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 32;

  typedef struct {
    bit             wen;
    int             addr;
    logic [DW-1:0]  d;
  } op_t;

  logic CLK = 1'b0;
  logic RST;

  int compared   = 0;
  int mismatched = 0;

  op_t sbA[$];
  op_t sbB[$];

  logic          startA, fCenA, fWenA, qDummyA;
  logic [AW-1:0] fAA;
  logic [DW-1:0] fDA, qA;
  logic          cenA, wenA, busyA, doneA, failA;
  logic [AW-1:0] aA, failAddrA;
  logic [DW-1:0] dA, failDataA, failExpA;
  logic [DW-1:0] memA [DEPTH_A];
  logic          stuckA;

  logic          startB, fCenB, fWenB;
  logic [AW-1:0] fAB;
  logic [DW-1:0] fDB, qB;
  logic          cenB, wenB, busyB, doneB, failB;
  logic [AW-1:0] aB, failAddrB;
  logic [DW-1:0] dB, failDataB, failExpB;
  logic [DW-1:0] memB [DEPTH_B];

  always #5 CLK = ~CLK;

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_A)) dutA (
    .CLK(CLK), .RST(RST), .start(startA),
    .func_CEN(fCenA), .func_WEN(fWenA), .func_A(fAA), .func_D(fDA), .Q_in(qA),
    .CEN(cenA), .WEN(wenA), .A(aA), .D(dA),
    .busy(busyA), .done(doneA), .fail(failA),
    .fail_addr(failAddrA), .fail_data(failDataA), .fail_expect(failExpA)
  );

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_B)) dutB (
    .CLK(CLK), .RST(RST), .start(startB),
    .func_CEN(fCenB), .func_WEN(fWenB), .func_A(fAB), .func_D(fDB), .Q_in(qB),
    .CEN(cenB), .WEN(wenB), .A(aB), .D(dB),
    .busy(busyB), .done(doneB), .fail(failB),
    .fail_addr(failAddrB), .fail_data(failDataB), .fail_expect(failExpB)
  );

  // Synchronous SRAM model for instance A, with an optional stuck-at-1 on bit 3 of address 5.
  always @(posedge CLK) begin
    if (!cenA) begin
      if (!wenA) memA[aA[3:0]] <= dA;
      else       qA <= memA[aA[3:0]] | ((stuckA && (aA == 18'd5)) ? 8'h08 : 8'h00);
    end
  end

  // Fault-free synchronous SRAM model for instance B.
  always @(posedge CLK) begin
    if (!cenB) begin
      if (!wenB) memB[aB[4:0]] <= dB;
      else       qB <= memB[aB[4:0]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushOp(input int which, input bit wen, input int addr, input logic [DW-1:0] d);
    op_t o;
    o.wen  = wen;
    o.addr = addr;
    o.d    = d;
    if (which == 0) sbA.push_back(o);
    else            sbB.push_back(o);
  endtask

  // Expected March C- bus sequence: reads appear twice (issue, then check on the same address).
  task automatic pushMarch(input int which, input int depth);
    for (int a = 0; a < depth; a++) pushOp(which, 1'b0, a, 8'h00);
    for (int a = 0; a < depth; a++) begin
      pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b0, a, 8'hFF);
    end
    for (int a = 0; a < depth; a++) begin
      pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b0, a, 8'h00);
    end
    for (int a = depth - 1; a >= 0; a--) begin
      pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b0, a, 8'hFF);
    end
    for (int a = depth - 1; a >= 0; a--) begin
      pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b0, a, 8'h00);
    end
    for (int a = 0; a < depth; a++) begin
      pushOp(which, 1'b1, a, 8'h00); pushOp(which, 1'b1, a, 8'h00);
    end
  endtask

  task automatic monitorPop(input int which, input logic cen, input logic wen,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t         o;
    logic [31:0] act;
    logic [31:0] exp;
    if ((which == 0 && sbA.size() == 0) || (which == 1 && sbB.size() == 0)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL sb%0d_underflow: got bus A=0x%0h WEN=%0b, expected no BIST cycle", which, a, wen);
      return;
    end
    if (which == 0) o = sbA.pop_front();
    else            o = sbB.pop_front();
    act = {4'b0, cen, wen, a, (wen ? 8'h00 : d)};
    exp = {4'b0, 1'b0, o.wen, AW'(o.addr), (o.wen ? 8'h00 : o.d)};
    checkOutput((which == 0) ? "A_busOp" : "B_busOp", act, exp);
  endtask

  // Monitor: every BIST-owned cycle is compared against the next expected bus operation.
  always @(negedge CLK) begin
    if (busyA) monitorPop(0, cenA, wenA, aA, dA);
    if (busyB) monitorPop(1, cenB, wenB, aB, dB);
  end

  task automatic applyStimulus(input int which);
    if (which == 0) begin pushMarch(0, DEPTH_A); startA = 1'b1; end
    else            begin pushMarch(1, DEPTH_B); startB = 1'b1; end
    @(negedge CLK);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Counts busy cycles (bounded); optionally pulses start on instance A at a given cycle.
  task automatic waitIdle(input int which, input int pulseAt, output int cycles);
    cycles = 0;
    while (((which == 0) ? busyA : busyB) && (cycles < 2000)) begin
      cycles++;
      if (cycles == pulseAt) startA = 1'b1;
      @(negedge CLK);
      startA = 1'b0;
    end
  endtask

  initial begin
    int cycles;
    int errs;
    RST = 1'b1; stuckA = 1'b0;
    startA = 1'b0; fCenA = 1'b0; fWenA = 1'b1; fAA = 18'h0_1234; fDA = 8'h00; qDummyA = 1'b0;
    startB = 1'b0; fCenB = 1'b1; fWenB = 1'b1; fAB = 18'h0_0000; fDB = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    checkOutput("rst_A_addr", aA, 18'h0_1234);
    checkOutput("rst_A_cen", cenA, 0);
    checkOutput("rst_A_busy", busyA, 0);
    checkOutput("rst_A_done", doneA, 0);
    checkOutput("rst_A_fail", failA, 0);
    checkOutput("rst_A_failAddr", failAddrA, 0);
    checkOutput("rst_B_busy", busyB, 0);

    $display("[TB] DEPTH=32 address-order run");
    applyStimulus(1);
    waitIdle(1, 0, cycles);
    checkOutput("B_busyCycles", cycles, 480);
    checkOutput("B_done", doneB, 1);
    checkOutput("B_fail", failB, 0);
    checkOutput("B_sbLeft", sbB.size(), 0);

    $display("[TB] DEPTH=16 fault-free run");
    applyStimulus(0);
    waitIdle(0, 0, cycles);
    checkOutput("A1_busyCycles", cycles, 240);
    checkOutput("A1_done", doneA, 1);
    checkOutput("A1_fail", failA, 0);
    checkOutput("A1_sbLeft", sbA.size(), 0);
    errs = 0;
    for (int i = 0; i < DEPTH_A; i++) if (memA[i] !== 8'h00) errs++;
    checkOutput("A1_memNonZero", errs, 0);
    repeat (3) @(negedge CLK);
    checkOutput("A1_doneHeld", doneA, 1);
    checkOutput("A1_passAddr", aA, 18'h0_1234);

    $display("[TB] stuck-at-1 bit 3 at address 5");
    stuckA = 1'b1;
    applyStimulus(0);
    checkOutput("A2_doneCleared", doneA, 0);
    checkOutput("A2_busy", busyA, 1);
    waitIdle(0, 0, cycles);
    checkOutput("A2_busyCycles", cycles, 33);
    checkOutput("A2_done", doneA, 1);
    checkOutput("A2_fail", failA, 1);
    checkOutput("A2_failAddr", failAddrA, 5);
    checkOutput("A2_failExpect", failExpA, 8'h00);
    checkOutput("A2_failData", failDataA, 8'h08);
    sbA.delete();

    $display("[TB] restart from failed DONE, then reset at cycle 50");
    stuckA = 1'b0;
    applyStimulus(0);
    checkOutput("A3_failCleared", failA, 0);
    checkOutput("A3_failAddrCleared", failAddrA, 0);
    checkOutput("A3_failDataCleared", failDataA, 0);
    checkOutput("A3_busy", busyA, 1);
    for (int i = 1; i < 50; i++) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("A3_rstBusy", busyA, 0);
    checkOutput("A3_rstDone", doneA, 0);
    checkOutput("A3_rstFail", failA, 0);
    checkOutput("A3_rstPassAddr", aA, 18'h0_1234);
    RST = 1'b0;
    sbA.delete();
    @(negedge CLK);

    $display("[TB] fresh run with start pulsed while busy");
    applyStimulus(0);
    waitIdle(0, 20, cycles);
    checkOutput("A4_busyCycles", cycles, 240);
    checkOutput("A4_done", doneA, 1);
    checkOutput("A4_fail", failA, 0);
    checkOutput("A4_sbLeft", sbA.size(), 0);
    errs = 0;
    for (int i = 0; i < DEPTH_A; i++) if (memA[i] !== 8'h00) errs++;
    checkOutput("A4_memNonZero", errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
